// File: rtl/vga_text_pkg.sv
// Shared 640x480@60 timing constants, the CGA palette and pixel colour type
// used by the VGA text scanner.
package vga_text_pkg;

  localparam logic [9:0] H_ACTIVE   = 10'd640;
  localparam logic [9:0] H_FP_END   = 10'd656;
  localparam logic [9:0] H_SYNC_END = 10'd752;
  localparam logic [9:0] H_TOTAL    = 10'd800;

  localparam logic [9:0] V_ACTIVE   = 10'd480;
  localparam logic [9:0] V_FP_END   = 10'd490;
  localparam logic [9:0] V_SYNC_END = 10'd492;
  localparam logic [9:0] V_TOTAL    = 10'd525;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t PALETTE [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider plus 800x525 raster counters; raw (undelayed) de,
// sync and vertical-blank flags decoded from the counters.
module vga_timing_gen
  import vga_text_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       tick,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       de,
  output logic       hs,
  output logic       vs,
  output logic       vblank
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_reg;
  logic [9:0]       h_reg;
  logic [9:0]       v_reg;

  assign tick = (div_reg == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg <= '0;
      h_reg   <= '0;
      v_reg   <= '0;
    end else begin
      div_reg <= tick ? '0 : div_reg + 1'b1;
      if (tick) begin
        if (h_reg == H_TOTAL - 10'd1) begin
          h_reg <= '0;
          v_reg <= (v_reg == V_TOTAL - 10'd1) ? '0 : v_reg + 10'd1;
        end else begin
          h_reg <= h_reg + 10'd1;
        end
      end
    end
  end

  assign h      = h_reg;
  assign v      = v_reg;
  assign de     = (h_reg < H_ACTIVE) && (v_reg < V_ACTIVE);
  assign hs     = !((h_reg >= H_FP_END) && (h_reg < H_SYNC_END));
  assign vs     = !((v_reg >= V_FP_END) && (v_reg < V_SYNC_END));
  assign vblank = (v_reg >= V_ACTIVE);

endmodule

// File: rtl/vga_text_scanner.sv
// Text-mode scan-out: cell fetch (A), font fetch (B), pixel render (C).
// Define VGA_TEXT_BLINK_EN to enable attribute bit7 blinking.
module vga_text_scanner
  import vga_text_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int COLS    = 80,
  parameter int ROWS    = 30
) (
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] VgaAddress,
  input  logic [7:0]  CharIn,
  input  logic [7:0]  ColorIn,
  output logic [11:0] FontAddr,
  input  logic [7:0]  FontData,
  output logic        Hsync,
  output logic        Vsync,
  output logic [3:0]  Red,
  output logic [3:0]  Green,
  output logic [3:0]  Blue,
  output logic        VBlank
);

  logic       tick, de, hs, vs;
  logic [9:0] h, v;

  vga_timing_gen #(.CLK_DIV(CLK_DIV)) u_timing (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .h      (h),
    .v      (v),
    .de     (de),
    .hs     (hs),
    .vs     (vs),
    .vblank (VBlank)
  );

  logic [6:0]  col;
  logic [5:0]  row;
  logic [11:0] addr_next;
  logic        cell_ok;

  assign col     = h[9:3];
  assign row     = v[9:4];
  assign cell_ok = de && (32'(col) < COLS) && (32'(row) < ROWS);

  generate
    if (COLS == 80) begin : g_row_x80
      assign addr_next = ({6'd0, row} << 6) + ({6'd0, row} << 4) + {5'd0, col};
    end else begin : g_row_mul
      assign addr_next = 12'({6'd0, row} * 12'(COLS)) + {5'd0, col};
    end
  endgenerate

  logic [2:0] xbit_a_reg, xbit_b_reg;
  logic [3:0] line_a_reg;
  logic       de_a_reg, hs_a_reg, vs_a_reg;
  logic       de_b_reg, hs_b_reg, vs_b_reg;
  logic [3:0] fg_b_reg, bg_b_reg;
  logic [3:0] fg_next;
  rgb12_t     rgb_reg;
  logic       pixel;

`ifdef VGA_TEXT_BLINK_EN
  logic [5:0] frame_reg;
  logic       blink_b_reg;

  assign fg_next = {1'b0, ColorIn[6:4]};
  assign pixel   = FontData[3'd7 - xbit_b_reg] & ~(blink_b_reg & frame_reg[5]);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_reg   <= '0;
      blink_b_reg <= 1'b0;
    end else if (tick) begin
      blink_b_reg <= ColorIn[7];
      if (h == H_TOTAL - 10'd1 && v == V_TOTAL - 10'd1)
        frame_reg <= frame_reg + 6'd1;
    end
  end
`else
  assign fg_next = ColorIn[7:4];
  assign pixel   = FontData[3'd7 - xbit_b_reg];
`endif

  // Sync copies reset to the inactive level so nothing glitches low out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      VgaAddress <= '0;
      xbit_a_reg <= '0;
      line_a_reg <= '0;
      de_a_reg   <= 1'b0;
      hs_a_reg   <= 1'b1;
      vs_a_reg   <= 1'b1;
      FontAddr   <= '0;
      xbit_b_reg <= '0;
      de_b_reg   <= 1'b0;
      hs_b_reg   <= 1'b1;
      vs_b_reg   <= 1'b1;
      fg_b_reg   <= '0;
      bg_b_reg   <= '0;
      rgb_reg    <= '0;
      Hsync      <= 1'b1;
      Vsync      <= 1'b1;
    end else if (tick) begin
      VgaAddress <= cell_ok ? addr_next : '0;
      xbit_a_reg <= h[2:0];
      line_a_reg <= v[3:0];
      de_a_reg   <= cell_ok;
      hs_a_reg   <= hs;
      vs_a_reg   <= vs;

      FontAddr   <= {CharIn, line_a_reg};
      xbit_b_reg <= xbit_a_reg;
      de_b_reg   <= de_a_reg;
      hs_b_reg   <= hs_a_reg;
      vs_b_reg   <= vs_a_reg;
      fg_b_reg   <= fg_next;
      bg_b_reg   <= ColorIn[3:0];

      rgb_reg    <= de_b_reg ? PALETTE[pixel ? fg_b_reg : bg_b_reg] : '0;
      Hsync      <= hs_b_reg;
      Vsync      <= vs_b_reg;
    end
  end

  assign Red   = rgb_reg[11:8];
  assign Green = rgb_reg[7:4];
  assign Blue  = rgb_reg[3:0];

endmodule

// File: doc/vga_text_scanner.md
Name: vga_text_scanner

Overview:
- Scan-out controller for the MMIO VGA text buffer.
- Generates 640x480@60 timing from the system clock, sequences reads of the char/colour RAM through the MMIO VGA read port (VgaAddress -> CharOut/ColorOut), looks up glyphs in an external synchronous font ROM, and drives 12-bit RGB plus syncs.
- Sits between the MMIO block and the board VGA pins.

Parameters:
- CLK_DIV, 4: clk cycles per pixel tick (100 MHz -> 25 MHz); legal values >= 2.
- COLS, 80: text columns (8-pixel-wide cells).
- ROWS, 30: text rows (16-pixel-tall cells).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- VgaAddress  out  12  text-buffer cell index to MMIO read port
- CharIn  in  8  character code for VgaAddress (combinational from MMIO)
- ColorIn  in  8  attribute for VgaAddress; [7:4] fg index, [3:0] bg index
- FontAddr  out  12  {char[7:0], glyph_line[3:0]} to font ROM
- FontData  in  8  glyph row, 1-clk synchronous ROM latency, bit7 = leftmost pixel
- Hsync  out  1  active-low
- Vsync  out  1  active-low
- Red/Green/Blue  out  4 each  pixel colour
- VBlank  out  1  high while v counter >= 480 (undelayed, for CPU polling)

Behaviour:
- Pixel tick: a divider counts 0..CLK_DIV-1; tick is asserted when the divider is at CLK_DIV-1. All counters and pipeline stages advance only on tick.
- h counter runs 0..799 and wraps to 0. On that wrap, v increments 0..524 and wraps to 0.
- Active region (de): h<640 and v<480.
- Sync timing: Hsync low for h in 656..751. Vsync low for v in 490..491.
- Stage A (tick k): VgaAddress <= de ? (v>>4)*80 + (h>>3) : 0. The multiply is implemented as (row<<6)+(row<<4). Maximum address is 2399; no address >= 2400 is ever issued. Also registered: xbit=h[2:0], line=v[3:0], de, hs, vs.
- Stage B (tick k+1): register CharIn and ColorIn; FontAddr <= {CharIn, line}. FontData is valid one clk later, which is guaranteed before the next tick because CLK_DIV>=2.
- Stage C (tick k+2): pixel = FontData[7-xbit]. RGB <= de ? palette[pixel ? fg : bg] : 0. Hsync/Vsync are registered here from the stage-B copies.
- Latency: syncs and RGB are aligned, 3 ticks behind the counters.
- Palette: fixed 16-entry CGA, 12-bit.
- Reset values: divider, h, v = 0; VgaAddress = 0; FontAddr = 0; RGB = 0; Hsync = 1; Vsync = 1; VBlank = 0; all pipeline de flags = 0.
- Reset mid-frame: all of the above apply on the next clk edge. Scan restarts at (0,0) on the first tick after reset deasserts. No partial-line output.
- CharIn/ColorIn change between ticks (CPU write): only the value present at the stage-B tick is used.

Optional Feature:
- Macro: VGA_TEXT_BLINK_EN.
- Defined:
  - A 6-bit frame counter increments at each v wrap; reset value 0.
  - Attribute bit7 = blink, fg = {1'b0, ColorIn[6:4]}.
  - When blink=1 and frame_cnt[5]=1, the pixel is forced to bg.
- Undefined: no frame counter; fg = ColorIn[7:4].

Decomposition:
- Package vga_text_pkg holds:
  - H_ACTIVE=640, H_FP_END=656, H_SYNC_END=752, H_TOTAL=800
  - V_ACTIVE=480, V_FP_END=490, V_SYNC_END=492, V_TOTAL=525
  - the 16-entry 12-bit palette constant array
  - typedef rgb12_t
- One sub-module: vga_timing_gen. It contains the divider, h/v counters, tick, de, raw hs/vs and VBlank. The fetch/render pipeline stays in vga_text_scanner.

Test Plan:
- Reset response: hold reset 10 clks -> Hsync=1, Vsync=1, RGB=0, VgaAddress=0, FontAddr=0. First tick after release has h=0, VgaAddress=0.
- Line and frame wrap: run to h=799, v=0 -> next tick gives h=0, v=1. At h=799, v=524 -> next tick gives v=0; VBlank is 1 for v=480..524 only.
- Sync timing: the output Hsync falling edge occurs 3 ticks after h=656, and Hsync stays low for exactly 96 ticks. Vsync is low for exactly 2 lines (1600 ticks).
- Address bound: at h=632, v=464 -> VgaAddress=2399. At h=640 (blank) -> VgaAddress=0.
- Glyph render: CharIn=0x41, ColorIn=0x1E, FontData=0x80 at cell (0,0) line 0 -> FontAddr=0x410. Output x=0 is palette[1], x=1..7 are palette[14], with RGB appearing 3 ticks after h=0.
- Blink (VGA_TEXT_BLINK_EN): ColorIn=0x9E, FontData=0xFF. Frames 0..31 show palette[1] on all 8 pixels; frames 32..63 show palette[14].
